// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared state encoding, frame constants and command-byte packing
package spi_mem_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_TURN, ST_DATA, ST_GAP} state_e;
  localparam int CMD_LENGTH = 8;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  function automatic logic [CMD_LENGTH-1:0] pack_cmd(input logic [CMD_LENGTH-2:0] addr, input logic rw);
    return {addr, rw};
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: mode-0 sclk generator with half-period CLK_DIV and edge ticks
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic rise_tick_o,
  output logic fall_tick_o,
  output logic sclk_o
);
  localparam int W = $clog2(CLK_DIV) + 1;
  logic [W-1:0] cnt_q, cnt_d;
  logic sclk_q, sclk_d, wrap;
  // tick generation; dropping enable returns to idle-low with a cleared count
  always_comb begin
    wrap = enable_i && cnt_q == W'(CLK_DIV - 1);
    rise_tick_o = wrap && !sclk_q;
    fall_tick_o = wrap && sclk_q;
    cnt_d = (!enable_i || wrap) ? '0 : cnt_q + 1'b1;
    sclk_d = enable_i && (sclk_q ^ wrap);
  end
  // divider state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
  assign sclk_o = sclk_q;
endmodule

// File: rtl/spi_mem_master.sv
// spi_mem_master: SPI mode-0 master sending one command byte plus one data word per request
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int ADDRESS_LENGTH = 4,
  parameter int CLK_DIV = 2,
  parameter int TURNAROUND = 4,
  parameter int SS_GAP = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      read_write,
  input  logic [ADDRESS_LENGTH-1:0] address,
  input  logic [DATA_LENGTH-1:0]    wdata,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_LENGTH-1:0]    rdata,
  output logic                      ss,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso
);
  localparam int FL = CMD_LENGTH + DATA_LENGTH;
  localparam int AW = CMD_LENGTH - 1;
  localparam int BW = $clog2(DATA_LENGTH);
  localparam int CW = $clog2(TURNAROUND + SS_GAP + 1);
  state_e state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [FL-1:0] tx_q, tx_d;
  logic [DATA_LENGTH-1:0] rx_q, rx_d, rdata_q, rdata_d;
  logic rw_q, rw_d;
  logic rise_tick, fall_tick, sclk_en, gap_last, accept;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .reset(reset),
    .enable_i(sclk_en),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick),
    .sclk_o(sclk)
  );

  // pin decode; the last gap cycle may accept a new request so frames can run back-to-back
  always_comb begin
    sclk_en = state_q == ST_CMD || state_q == ST_DATA;
    gap_last = state_q == ST_GAP && cyc_q == CW'(SS_GAP - 1);
    accept = start && (state_q == ST_IDLE || gap_last);
    ss = !(sclk_en || state_q == ST_TURN);
    mosi = sclk_en && tx_q[FL-1];
    busy = state_q != ST_IDLE;
    done = gap_last;
    rdata = (done && rw_q == RW_READ) ? rx_q : rdata_q;
  end

  // next-state logic: phases advance on the final falling tick of their last bit
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    cyc_d = cyc_q;
    tx_d = fall_tick ? tx_q << 1 : tx_q;
    rx_d = (rise_tick && state_q == ST_DATA) ? {rx_q[DATA_LENGTH-2:0], miso} : rx_q;
    rw_d = rw_q;
    rdata_d = (done && rw_q == RW_READ) ? rx_q : rdata_q;
    case (state_q)
      ST_CMD: if (fall_tick) begin
        bit_d = bit_q == BW'(CMD_LENGTH - 1) ? '0 : bit_q + 1'b1;
        if (bit_q == BW'(CMD_LENGTH - 1)) state_d = TURNAROUND > 0 ? ST_TURN : ST_DATA;
      end
      ST_TURN: begin
        cyc_d = cyc_q == CW'(TURNAROUND - 1) ? '0 : cyc_q + 1'b1;
        if (cyc_q == CW'(TURNAROUND - 1)) state_d = ST_DATA;
      end
      ST_DATA: if (fall_tick) begin
        bit_d = bit_q == BW'(DATA_LENGTH - 1) ? '0 : bit_q + 1'b1;
        if (bit_q == BW'(DATA_LENGTH - 1)) state_d = ST_GAP;
      end
      ST_GAP: begin
        cyc_d = gap_last ? '0 : cyc_q + 1'b1;
        if (gap_last) state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      state_d = ST_CMD;
      rw_d = read_write;
      bit_d = '0;
      cyc_d = '0;
      tx_d = {pack_cmd(AW'(address), read_write), read_write == RW_WRITE ? wdata : {DATA_LENGTH{1'b0}}};
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q <= '0;
      cyc_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rw_q <= RW_WRITE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      cyc_q <= cyc_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rw_q <= rw_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: scoreboard bench with a behavioural mode-0 memory slave
module tb_spi_mem_master;
  localparam int DL = 32;
  localparam int AL = 4;
  localparam int CD = 2;
  localparam int TA = 4;
  localparam int SG = 2;
  localparam int L = 2 * CD * (8 + DL) + TA;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, read_write = 1'b0, miso = 1'b0;
  logic [AL-1:0] address = '0;
  logic [DL-1:0] wdata = '0;
  logic busy, done, ss, sclk, mosi;
  logic [DL-1:0] rdata;

  spi_mem_master #(.DATA_LENGTH(DL), .ADDRESS_LENGTH(AL), .CLK_DIV(CD), .TURNAROUND(TA), .SS_GAP(SG)) dut (
    .clk(clk), .reset(reset), .start(start), .read_write(read_write), .address(address),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .ss(ss), .sclk(sclk),
    .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int done_cyc;
    logic [7:0] cmd;
    logic [DL-1:0] data;
    logic [DL-1:0] rd;
  } exp_t;
  exp_t q[$];
  logic [DL-1:0] model_mem [16] = '{default: '0};
  logic [DL-1:0] model_rd = '0;
  bit run = 0, chk_gap = 0;
  int hi_run = 0;

  logic [DL-1:0] smem [16] = '{default: '0};
  logic s_ss_p = 1'b1, s_clk_p = 1'b0, s_rd = 1'b0;
  logic [3:0] s_addr = '0;
  int s_bits = 0, s_last_bits = 0;
  logic [39:0] s_sr = '0, s_frame = '0;
  logic [DL-1:0] s_sh = '0;

  // mode-0 slave: sample mosi on sclk rise, shift miso on sclk fall, commit writes when ss rises
  always @(ss or sclk) begin
    if (ss === 1'b0 && s_ss_p !== 1'b0) begin
      s_bits = 0;
      s_sr = '0;
    end
    if (ss === 1'b1 && s_ss_p === 1'b0) begin
      s_frame = s_sr;
      s_last_bits = s_bits;
      if (s_bits == 40 && !s_rd) smem[s_addr] = s_sr[31:0];
    end
    if (ss === 1'b0 && sclk === 1'b1 && s_clk_p === 1'b0) begin
      s_sr = {s_sr[38:0], mosi};
      s_bits++;
    end
    if (ss === 1'b0 && sclk === 1'b0 && s_clk_p === 1'b1) begin
      if (s_bits == 8) begin
        s_rd = s_sr[0];
        s_addr = s_sr[4:1];
        s_sh = smem[s_sr[4:1]];
        if (s_sr[0]) miso = s_sh[31];
      end else if (s_bits > 8 && s_rd) begin
        s_sh = {s_sh[30:0], 1'b0};
        miso = s_sh[31];
      end
    end
    s_ss_p = ss;
    s_clk_p = sclk;
  end

  // monitor: idle pin levels, ss gap length, and scoreboard pop on every done
  always @(negedge clk) begin : mon
    exp_t e;
    if (run) begin
      if (ss === 1'b1) begin
        check("idle_sclk_mosi", {sclk, mosi}, 2'b00);
        hi_run++;
      end else begin
        if (chk_gap && hi_run > 0) check("ss_gap", hi_run, SG);
        hi_run = 0;
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("rdata", rdata, e.rd);
          check("slave_bits", s_last_bits, 40);
          check("slave_frame", s_frame, {e.cmd, e.data});
        end
      end
    end
  end

  // issue one frame at a negedge; returns at the negedge of its done cycle
  task automatic frame(input logic rw, input logic [3:0] a, input logic [DL-1:0] d, input bit hold, input bit pulse);
    exp_t e;
    read_write = rw;
    address = a;
    wdata = d;
    start = 1'b1;
    e.done_cyc = cyc + L + SG;
    e.cmd = {3'b000, a, rw};
    e.data = rw ? '0 : d;
    if (rw) model_rd = model_mem[a];
    else model_mem[a] = d;
    e.rd = model_rd;
    q.push_back(e);
    for (int k = 1; k <= L + SG; k++) begin
      @(negedge clk);
      start = hold || (pulse && (k == 5 || k == 50));
      if (pulse && start) begin
        read_write = 1'($urandom);
        address = 4'($urandom);
        wdata = $urandom;
      end
    end
    chk_gap = hold;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run = 1;
    repeat (10) begin
      @(negedge clk);
      check("reset_pins", {ss, sclk, mosi, busy, done, rdata}, {1'b1, 4'b0000, 32'h0});
    end
    frame(1'b0, 4'h3, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    check("busy_after_write", busy, 1'b0);
    frame(1'b1, 4'h3, '0, 0, 0);
    @(negedge clk);
    check("busy_after_read", busy, 1'b0);
    frame(1'b0, 4'hA, 32'h12345678, 1, 0);
    frame(1'b1, 4'hA, '0, 1, 0);
    frame(1'b1, 4'h0, '0, 0, 0);
    @(negedge clk);
    frame(1'b0, 4'h5, $urandom, 0, 1);
    @(negedge clk);
    read_write = 1'b0;
    address = 4'h3;
    wdata = 32'hCAFEF00D;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ss", ss, 1'b1);
    check("abort_busy", busy, 1'b0);
    reset = 1'b0;
    model_rd = '0;
    repeat (200) @(negedge clk);
    frame(1'b1, 4'h3, '0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 12; i++) frame(1'($urandom), 4'($urandom), $urandom, 1'($urandom_range(0, 1)), 0);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
